// File: rtl/add_1b_pkg.sv
// Shared definitions for the add_1b full-adder slice: counter width default,
// adder implementation selector and the arithmetic reference function.
package add_1b_pkg;

  localparam int unsigned CNT_W_DEFAULT = 8;

  typedef enum logic {
    FA_GATE  = 1'b0,
    FA_ARITH = 1'b1
  } fa_impl_e;

  // Returns {co, r} from a widened 2-bit add.
  function automatic logic [1:0] fa_sum_carry(input logic a, input logic b, input logic ci);
    logic [1:0] s;
    s = {1'b0, a} + {1'b0, b} + {1'b0, ci};
    return s;
  endfunction

endpackage

// File: rtl/add_1b_core.sv
// Combinational 1-bit full adder; IMPL picks the gate-level or the
// arithmetic formulation so a checker copy can differ structurally.
module add_1b_core
  import add_1b_pkg::*;
#(
  parameter fa_impl_e IMPL = FA_GATE
) (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic r_o,
  output logic co_o
);

  generate
    if (IMPL == FA_ARITH) begin : g_arith
      assign {co_o, r_o} = fa_sum_carry(a_i, b_i, ci_i);
    end else begin : g_gate
      assign r_o  = a_i ^ b_i ^ ci_i;
      assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
    end
  endgenerate

endmodule

// File: rtl/add_1b.sv
// Full adder with registered capture, saturating carry-event counter and an
// optional sticky self-check (define ADD_1B_CHECK_EN to add port err).
module add_1b
  import add_1b_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             ci,
  output logic             r,
  output logic             co,
  input  logic             vld_i,
  output logic             r_q,
  output logic             co_q,
  output logic             vld_q,
  output logic [CNT_W-1:0] cnt_q,
  output logic             cnt_sat
`ifdef ADD_1B_CHECK_EN
  ,
  output logic             err
`endif
);

  logic             r_d;
  logic             co_d;
  logic             vld_d;
  logic [CNT_W-1:0] cnt_d;

  add_1b_core #(
    .IMPL (FA_GATE)
  ) u_core (
    .a_i  (a),
    .b_i  (b),
    .ci_i (ci),
    .r_o  (r),
    .co_o (co)
  );

  assign cnt_sat = (cnt_q == '1);

  always_comb begin
    r_d   = r_q;
    co_d  = co_q;
    cnt_d = cnt_q;
    vld_d = vld_i;
    if (vld_i) begin
      r_d  = r;
      co_d = co;
      if (co && !cnt_sat) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= 1'b0;
      co_q  <= 1'b0;
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      r_q   <= r_d;
      co_q  <= co_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef ADD_1B_CHECK_EN
  logic chk_r;
  logic chk_co;
  logic err_d;

  add_1b_core #(
    .IMPL (FA_ARITH)
  ) u_core_chk (
    .a_i  (a),
    .b_i  (b),
    .ci_i (ci),
    .r_o  (chk_r),
    .co_o (chk_co)
  );

  assign err_d = err | (r ^ chk_r) | (co ^ chk_co);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_add_1b.sv
// Scoreboard bench for add_1b (CNT_W=2): captures push expected results,
// a negedge monitor pops and compares whenever vld_q is presented.
module tb_add_1b;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic       a;
  logic       b;
  logic       ci;
  logic       r;
  logic       co;
  logic       vld_i;
  logic       r_q;
  logic       co_q;
  logic       vld_q;
  logic [1:0] cnt_q;
  logic       cnt_sat;
`ifdef ADD_1B_CHECK_EN
  logic       err;
`endif

  typedef struct {
    logic       r;
    logic       co;
    logic [1:0] cnt;
    logic       sat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  add_1b #(
    .CNT_W (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .ci      (ci),
    .r       (r),
    .co      (co),
    .vld_i   (vld_i),
    .r_q     (r_q),
    .co_q    (co_q),
    .vld_q   (vld_q),
    .cnt_q   (cnt_q),
    .cnt_sat (cnt_sat)
`ifdef ADD_1B_CHECK_EN
    ,
    .err     (err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic ia, input logic ib, input logic ici,
                       input logic er, input logic eco, input logic [1:0] ecnt, input logic esat);
    exp_t e;
    a     = ia;
    b     = ib;
    ci    = ici;
    vld_i = 1'b1;
    e.r   = er;
    e.co  = eco;
    e.cnt = ecnt;
    e.sat = esat;
    exp_q.push_back(e);
  endtask

  // Monitor: compare each presented capture against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && vld_q === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_vld_q: got vld_q=1 expected no capture at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("cap_r_q", r_q, e.r);
          check("cap_co_q", co_q, e.co);
          check("cap_cnt_q", cnt_q, e.cnt);
          check("cap_cnt_sat", cnt_sat, e.sat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tt_r;
    logic [7:0] tt_co;
    logic [2:0] v;
    tt_r   = 8'h96;
    tt_co  = 8'hE8;
    clk_en = 1'b0;
    rst_n  = 1'b1;
    a      = 1'b0;
    b      = 1'b0;
    ci     = 1'b0;
    vld_i  = 1'b0;
    #1 rst_n = 1'b0;
    #100;

    check("rst_r_q", r_q, 1'b0);
    check("rst_co_q", co_q, 1'b0);
    check("rst_vld_q", vld_q, 1'b0);
    check("rst_cnt_q", cnt_q, 2'd0);
    check("rst_cnt_sat", cnt_sat, 1'b0);
    check("static_r0", r, 1'b0);
    check("static_co0", co, 1'b0);
    a = 1'b1;
    #1;
    check("static_r", r, 1'b1);
    check("static_co", co, 1'b0);

    for (int unsigned i = 0; i < 8; i++) begin
      v = 3'(i);
      {a, b, ci} = v;
      #1;
      check($sformatf("tt_r_%0d", i), r, tt_r[i]);
      check($sformatf("tt_co_%0d", i), co, tt_co[i]);
    end

    // Release reset and capture on the very first edge.
    clk_en = 1'b1;
    step();
    rst_n = 1'b1;
    issue(1, 1, 0, 0, 1, 2'd1, 0);
    step();
    vld_i = 1'b0;
    a = 1'b0; b = 1'b0; ci = 1'b1;
    step();
    check("hold_vld_q", vld_q, 1'b0);
    check("hold_r_q", r_q, 1'b0);
    check("hold_co_q", co_q, 1'b1);
    check("hold_cnt_q", cnt_q, 2'd1);

    // Saturation from a fresh reset, back-to-back captures.
    rst_n = 1'b0;
    #1;
    check("rst2_cnt_q", cnt_q, 2'd0);
    rst_n = 1'b1;
    issue(1, 1, 0, 0, 1, 2'd1, 0); step();
    issue(1, 0, 1, 0, 1, 2'd2, 0); step();
    issue(0, 1, 1, 0, 1, 2'd3, 1); step();
    issue(1, 1, 1, 1, 1, 2'd3, 1); step();
    issue(1, 1, 0, 0, 1, 2'd3, 1); step();
    check("sat_vld_q", vld_q, 1'b1);
    check("sat_cnt_q", cnt_q, 2'd3);

    // Mid-cycle async reset with a capture pending.
    a = 1'b1; b = 1'b1; ci = 1'b1; vld_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_r_q", r_q, 1'b0);
    check("arst_co_q", co_q, 1'b0);
    check("arst_vld_q", vld_q, 1'b0);
    check("arst_cnt_q", cnt_q, 2'd0);
    check("arst_cnt_sat", cnt_sat, 1'b0);
    a = 1'b0; b = 1'b1; ci = 1'b0;
    #1;
    check("arst_track_r", r, 1'b1);
    check("arst_track_co", co, 1'b0);
    a = 1'b1; ci = 1'b1; b = 1'b0;
    #1;
    check("arst_track_r2", r, 1'b0);
    check("arst_track_co2", co, 1'b1);
    step();
    step();
    check("arst_hold_vld_q", vld_q, 1'b0);
    check("arst_hold_cnt_q", cnt_q, 2'd0);
    vld_i = 1'b0;
    rst_n = 1'b1;
    step();
    check("post_rst_vld_q", vld_q, 1'b0);
    check("post_rst_cnt_q", cnt_q, 2'd0);

    // Mixed captures with and without carry, including an idle gap.
    issue(0, 0, 0, 0, 0, 2'd0, 0); step();
    issue(1, 0, 0, 1, 0, 2'd0, 0); step();
    issue(0, 1, 1, 0, 1, 2'd1, 0); step();
    vld_i = 1'b0;
    a = 1'b1; b = 1'b1; ci = 1'b1;
    step();
    check("gap_vld_q", vld_q, 1'b0);
    check("gap_r_q", r_q, 1'b0);
    check("gap_co_q", co_q, 1'b1);
    check("gap_cnt_q", cnt_q, 2'd1);
    issue(1, 0, 1, 0, 1, 2'd2, 0); step();
    issue(1, 1, 1, 1, 1, 2'd3, 1); step();
    vld_i = 1'b0;
    step();

    // Clocked sweep so the checker sees every input combination.
    for (int unsigned i = 0; i < 8; i++) begin
      v = 3'(i);
      {a, b, ci} = v;
      step();
    end
`ifdef ADD_1B_CHECK_EN
    check("chk_err", err, 1'b0);
`endif

    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/add_1b.md
ADD_1B -- requirements
Module: add_1b

Interface
REQ-001 Parameter CNT_W, default 8: width of the carry-event counter, legal range 2..32.
REQ-002 clk  input  1  single rising-edge clock for all sequential logic.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 a  input  1  addend bit.
REQ-005 b  input  1  addend bit.
REQ-006 ci  input  1  carry-in bit.
REQ-007 r  output  1  combinational sum bit.
REQ-008 co  output  1  combinational carry-out bit.
REQ-009 vld_i  input  1  marks the current a/b/ci as a sample to capture.
REQ-010 r_q  output  1  registered sum of the last captured sample.
REQ-011 co_q  output  1  registered carry of the last captured sample.
REQ-012 vld_q  output  1  high for exactly one cycle, one cycle after vld_i.
REQ-013 cnt_q  output  CNT_W  count of captured samples with carry-out 1.
REQ-014 cnt_sat  output  1  high while cnt_q equals its all-ones value.
REQ-015 err  output  1  self-check mismatch flag; present only when ADD_1B_CHECK_EN is defined.

Function
REQ-016 r SHALL equal a XOR b XOR ci, purely combinational, independent of clk and rst_n.
REQ-017 co SHALL equal majority(a,b,ci) = (a&b)|(a&ci)|(b&ci), purely combinational, independent of clk and rst_n.
REQ-018 r and co SHALL settle within 1 ns of any input change in zero-delay simulation, with no clock edge required.
REQ-019 On a rising clk edge with vld_i=1, r_q and co_q SHALL load r and co, and vld_q SHALL be set to 1.
REQ-020 On a rising clk edge with vld_i=0, r_q and co_q SHALL hold their values, and vld_q SHALL be cleared to 0.
REQ-021 Latency from vld_i to vld_q/r_q/co_q SHALL be exactly 1 cycle; back-to-back vld_i SHALL be accepted every cycle, with no stall and no backpressure.
REQ-022 cnt_q SHALL increment by 1 on each captured sample with co=1, and SHALL saturate at all-ones without wrapping.
REQ-023 cnt_sat SHALL be combinational from cnt_q (cnt_q == 2^CNT_W-1).
REQ-024 Inputs are not required to be stable outside capture edges.

Reset
REQ-025 When rst_n=0, r_q, co_q, vld_q and cnt_q SHALL go to 0 immediately, without waiting for a clock edge; err SHALL go to 0 as well.
REQ-026 Reset SHALL NOT affect the combinational outputs r and co.
REQ-027 Release of rst_n SHALL take effect on the first clk edge after deassertion.
REQ-028 A vld_i that coincides with that first edge SHALL be captured.
REQ-029 Reset asserted mid-stream SHALL discard any pending capture.

Configuration
REQ-030 With macro ADD_1B_CHECK_EN defined, the block SHALL include a second, independent sum/carry computation (r = (a+b+ci)[0], co = (a+b+ci)[1], 2-bit add).
REQ-031 With ADD_1B_CHECK_EN defined, err SHALL be a sticky register set on any clk edge where the two computations differ; it is cleared only by reset.
REQ-032 Without ADD_1B_CHECK_EN, the err port and the checker logic SHALL be absent.
REQ-033 All other behaviour SHALL be identical with and without ADD_1B_CHECK_EN.

Structure
REQ-034 The shared package add_1b_pkg SHALL hold CNT_W_DEFAULT, the default counter width (8).
REQ-035 add_1b_pkg SHALL hold a function fa_sum_carry(a,b,ci) returning a 2-bit {co,r}.
REQ-036 A single sub-module, add_1b_core, SHALL implement the combinational full adder.
REQ-037 The top level SHALL instantiate add_1b_core once, plus a second instance when ADD_1B_CHECK_EN is defined.

Verification
REQ-038 Static combinational test:
- stimulus: rst_n=0, no clock toggled; a=b=ci=0, wait 100 ns, then set a=1 and wait 1 ns
- response: r=1, co=0
REQ-039 Exhaustive combinational test:
- stimulus: all 8 combinations of a/b/ci
- response: r/co match the truth table; (1,1,1) gives r=1, co=1; (0,1,1) gives r=0, co=1
REQ-040 Capture test:
- stimulus: vld_i pulse with a=1, b=1, ci=0
- response: next cycle r_q=0, co_q=1, vld_q=1, cnt_q=1; the following cycle vld_q=0 and r_q/co_q hold
REQ-041 Saturation test:
- stimulus: CNT_W=2, 5 consecutive captures with co=1
- response: cnt_q sequence 1,2,3,3,3; cnt_sat=1 from the third capture on
REQ-042 Async reset test:
- stimulus: assert rst_n=0 between clock edges while cnt_q=3, vld_q=1
- response: all registered outputs 0 immediately; r/co keep tracking the inputs
REQ-043 Checker test (ADD_1B_CHECK_EN defined):
- stimulus: run the exhaustive sweep
- response: err stays 0
